hls_macc_result_packer: RTL and testbench

//  Downstream stage of the hls_macc core. Captures the three valid-qualified results (out13, out30, out31)
//  in the cycle the core asserts them, buffers each result triple in a small FIFO, and serialises triples
//  as a 3-word valid/ready stream to the next consumer. Also returns a start-permit signal so the

---
 rtl/hls_macc_pkg.sv | 33 +++
 rtl/hls_macc_triple_fifo.sv | 53 +++++
 rtl/hls_macc_result_packer.sv | 191 +++++++++++++++++++
 tb/tb_hls_macc_result_packer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/hls_macc_pkg.sv
// Shared types for the hls_macc result packer: result triple, serialiser states, words per triple.
// HLS_MACC_PACKER_CKSUM_EN adds a fourth XOR checksum word to every triple.
package hls_macc_pkg;

  localparam int unsigned RESULT_DW = 32;

  typedef struct packed {
    logic [RESULT_DW-1:0] out31;
    logic [RESULT_DW-1:0] out30;
    logic [RESULT_DW-1:0] out13;
  } triple_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W0   = 3'd1,
    W1   = 3'd2,
    W2   = 3'd3,
    W3   = 3'd4
  } ser_state_t;

`ifdef HLS_MACC_PACKER_CKSUM_EN
  localparam int unsigned WORDS_PER_TRIPLE = 4;
  localparam ser_state_t  LAST_STATE       = W3;
`else
  localparam int unsigned WORDS_PER_TRIPLE = 3;
  localparam ser_state_t  LAST_STATE       = W2;
`endif

  function automatic logic [RESULT_DW-1:0] triple_cksum(input triple_t t);
    return t.out13 ^ t.out30 ^ t.out31;
  endfunction

endpackage

// File: rtl/hls_macc_triple_fifo.sv
// Synchronous FIFO of result triples with registered full/empty/occupancy.
// dout shows the entry that is head after this cycle's pop, so the reader can chain triples without a bubble.
module hls_macc_triple_fifo
  import hls_macc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  triple_t                din,
  output triple_t                dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  triple_t        mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_sel;
  logic [OW-1:0]  occ_nxt;

  assign occ_nxt = occupancy + OW'(push) - OW'(pop);
  assign rd_sel  = pop ? (rd_ptr + AW'(1)) : rd_ptr;
  assign dout    = mem[rd_sel];

  // Storage array, no reset needed
  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      occupancy <= occ_nxt;
      empty     <= (occ_nxt == OW'(0));
      full      <= (occ_nxt == OW'(DEPTH));
    end
  end

endmodule

// File: rtl/hls_macc_result_packer.sv
// Captures hls_macc result triples into a FIFO and serialises them as a word stream with tlast.
// HLS_MACC_PACKER_CKSUM_EN appends an out13^out30^out31 word (state W3) to each triple.
module hls_macc_result_packer
  import hls_macc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = RESULT_DW,
  parameter int unsigned CNT_W = 8
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [DW-1:0]    out13,
  input  logic             out13_ap_vld,
  input  logic [DW-1:0]    out30,
  input  logic             out30_ap_vld,
  input  logic [DW-1:0]    out31,
  input  logic             out31_ap_vld,
  output logic             start_allow,
  output logic [DW-1:0]    m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  input  logic             clear_err,
  output logic             err_vld_mis,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic             cap;
  logic             any_vld;
  logic             vld_mis;
  logic             beat;
  logic             pop;
  logic             push;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OCC_W-1:0] fifo_occ;
  logic [OCC_W-1:0] occ_nxt;
  triple_t          fifo_din;
  triple_t          fifo_dout;

  ser_state_t       state_q;
  ser_state_t       state_d;
  logic             tvalid_d;
  logic             tlast_d;
  logic [DW-1:0]    tdata_d;

  assign cap      = out13_ap_vld & out30_ap_vld & out31_ap_vld;
  assign any_vld  = out13_ap_vld | out30_ap_vld | out31_ap_vld;
  assign vld_mis  = any_vld & ~cap;
  assign beat     = m_tvalid & m_tready;
  assign pop      = beat & (state_q == LAST_STATE);
  // A pop in the same cycle frees the slot the new triple lands in
  assign push     = cap & (~fifo_full | pop);
  assign drop     = cap & fifo_full & ~pop;
  assign occ_nxt  = fifo_occ + OCC_W'(push) - OCC_W'(pop);
  assign fifo_din = '{out31: out31, out30: out30, out13: out13};

  hls_macc_triple_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .push      (push),
    .pop       (pop),
    .din       (fifo_din),
    .dout      (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (fifo_occ)
  );

  // Serialiser next state and next registered stream outputs; hold while stalled
  always_comb begin
    state_d  = state_q;
    tvalid_d = m_tvalid;
    tdata_d  = m_tdata;
    tlast_d  = m_tlast;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d  = W0;
          tvalid_d = 1'b1;
          tdata_d  = fifo_dout.out13;
          tlast_d  = 1'b0;
        end
      end
      W0: begin
        if (beat) begin
          state_d = W1;
          tdata_d = fifo_dout.out30;
        end
      end
      W1: begin
        if (beat) begin
          state_d = W2;
          tdata_d = fifo_dout.out31;
`ifndef HLS_MACC_PACKER_CKSUM_EN
          tlast_d = 1'b1;
`endif
        end
      end
      W2: begin
        if (beat) begin
`ifdef HLS_MACC_PACKER_CKSUM_EN
          state_d = W3;
          tdata_d = triple_cksum(fifo_dout);
          tlast_d = 1'b1;
`else
          // fifo_dout already shows the following entry because pop is high
          if (fifo_occ >= OCC_W'(2)) begin
            state_d = W0;
            tdata_d = fifo_dout.out13;
            tlast_d = 1'b0;
          end else begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tlast_d  = 1'b0;
          end
`endif
        end
      end
`ifdef HLS_MACC_PACKER_CKSUM_EN
      W3: begin
        if (beat) begin
          if (fifo_occ >= OCC_W'(2)) begin
            state_d = W0;
            tdata_d = fifo_dout.out13;
            tlast_d = 1'b0;
          end else begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tlast_d  = 1'b0;
          end
        end
      end
`endif
      default: begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
        tdata_d  = '0;
        tlast_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= IDLE;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_tvalid <= tvalid_d;
      m_tdata  <= tdata_d;
      m_tlast  <= tlast_d;
    end
  end

  // One slot is kept free for the triple the non-pipelined core may have in flight
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) start_allow <= 1'b1;
    else           start_allow <= (occ_nxt <= OCC_W'(DEPTH - 2));
  end

  // Sticky error flags and saturating drop counter; clear wins over set
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      err_vld_mis <= 1'b0;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
    end else if (clear_err) begin
      err_vld_mis <= 1'b0;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      if (vld_mis) err_vld_mis <= 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hls_macc_result_packer.sv
// Directed self-checking bench for hls_macc_result_packer; follows HLS_MACC_PACKER_CKSUM_EN when defined.
module tb_hls_macc_result_packer;
  import hls_macc_pkg::*;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [31:0] out13, out30, out31;
  logic        out13_ap_vld, out30_ap_vld, out31_ap_vld;
  logic        start_allow;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic        clear_err;
  logic        err_vld_mis, overflow;
  logic [7:0]  drop_cnt;

  int n_chk = 0;
  int n_bad = 0;

  always #5 ap_clk = ~ap_clk;

  hls_macc_result_packer #(
    .DEPTH (4),
    .DW    (32),
    .CNT_W (8)
  ) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .out13        (out13),
    .out13_ap_vld (out13_ap_vld),
    .out30        (out30),
    .out30_ap_vld (out30_ap_vld),
    .out31        (out31),
    .out31_ap_vld (out31_ap_vld),
    .start_allow  (start_allow),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .clear_err    (clear_err),
    .err_vld_mis  (err_vld_mis),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the triple is captured at the next posedge
  task automatic drive_triple(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    out13 = a; out30 = b; out31 = c;
    out13_ap_vld = 1'b1; out30_ap_vld = 1'b1; out31_ap_vld = 1'b1;
    @(negedge ap_clk);
    out13_ap_vld = 1'b0; out30_ap_vld = 1'b0; out31_ap_vld = 1'b0;
  endtask

  // Word must be on the bus now; with m_tready=1 it is consumed at the next posedge
  task automatic recv_word(input string tag, input logic [31:0] d, input logic l);
    check({tag, "_vld"}, 32'(m_tvalid), 32'(1));
    check({tag, "_data"}, m_tdata, d);
    check({tag, "_last"}, 32'(m_tlast), 32'(l));
    @(negedge ap_clk);
  endtask

  task automatic recv_triple(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c);
    recv_word({tag, "_w0"}, a, 1'b0);
    recv_word({tag, "_w1"}, b, 1'b0);
`ifdef HLS_MACC_PACKER_CKSUM_EN
    recv_word({tag, "_w2"}, c, 1'b0);
    recv_word({tag, "_w3"}, a ^ b ^ c, 1'b1);
`else
    recv_word({tag, "_w2"}, c, 1'b1);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tvalid"}, 32'(m_tvalid), 32'(0));
    check({tag, "_tlast"}, 32'(m_tlast), 32'(0));
    check({tag, "_tdata"}, m_tdata, 32'(0));
    check({tag, "_allow"}, 32'(start_allow), 32'(1));
    check({tag, "_mis"}, 32'(err_vld_mis), 32'(0));
    check({tag, "_ovf"}, 32'(overflow), 32'(0));
    check({tag, "_drop"}, 32'(drop_cnt), 32'(0));
  endtask

  initial begin
    bit found;
    ap_rst_n = 1'b0;
    out13 = '0; out30 = '0; out31 = '0;
    out13_ap_vld = 1'b0; out30_ap_vld = 1'b0; out31_ap_vld = 1'b0;
    m_tready = 1'b0;
    clear_err = 1'b0;
    repeat (3) @(negedge ap_clk);
    check_idle_outputs("rst");
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check_idle_outputs("rst_rel");

    // 1: single triple, one-edge latency, consecutive words
    m_tready = 1'b1;
    drive_triple(32'd5, 32'd7, 32'd9);
    check("t1_not_yet", 32'(m_tvalid), 32'(0));
    check("t1_allow_a", 32'(start_allow), 32'(1));
    @(negedge ap_clk);
    recv_triple("t1", 32'd5, 32'd7, 32'd9);
    check("t1_done", 32'(m_tvalid), 32'(0));
    check("t1_allow_b", 32'(start_allow), 32'(1));

    // 2: backpressure holds W0 stable
    m_tready = 1'b0;
    drive_triple(32'd5, 32'd7, 32'd9);
    @(negedge ap_clk);
    for (int i = 0; i < 10; i++) begin
      check("t2_hold_vld", 32'(m_tvalid), 32'(1));
      check("t2_hold_data", m_tdata, 32'd5);
      @(negedge ap_clk);
    end
    m_tready = 1'b1;
    recv_triple("t2", 32'd5, 32'd7, 32'd9);
    check("t2_done", 32'(m_tvalid), 32'(0));

    // 3: fill to full, drop the fifth, drain the four in order
    m_tready = 1'b0;
    drive_triple(32'h11, 32'h12, 32'h13);
    drive_triple(32'h21, 32'h22, 32'h23);
    check("t3_allow_2", 32'(start_allow), 32'(1));
    drive_triple(32'h31, 32'h32, 32'h33);
    check("t3_allow_3", 32'(start_allow), 32'(0));
    drive_triple(32'h41, 32'h42, 32'h43);
    check("t3_ovf_4", 32'(overflow), 32'(0));
    drive_triple(32'h51, 32'h52, 32'h53);
    check("t3_ovf_5", 32'(overflow), 32'(1));
    check("t3_drop_5", 32'(drop_cnt), 32'(1));
    m_tready = 1'b1;
    recv_triple("t3a", 32'h11, 32'h12, 32'h13);
    recv_triple("t3b", 32'h21, 32'h22, 32'h23);
    recv_triple("t3c", 32'h31, 32'h32, 32'h33);
    recv_triple("t3d", 32'h41, 32'h42, 32'h43);
    check("t3_done", 32'(m_tvalid), 32'(0));
    @(negedge ap_clk);
    check("t3_no_fifth", 32'(m_tvalid), 32'(0));
    check("t3_allow_end", 32'(start_allow), 32'(1));

    // 4: lone vld pulse flags a mismatch and writes nothing; then clear
    out30 = 32'hdead;
    out30_ap_vld = 1'b1;
    @(negedge ap_clk);
    out30_ap_vld = 1'b0;
    check("t4_mis", 32'(err_vld_mis), 32'(1));
    for (int i = 0; i < 4; i++) begin
      check("t4_no_out", 32'(m_tvalid), 32'(0));
      @(negedge ap_clk);
    end
    clear_err = 1'b1;
    @(negedge ap_clk);
    clear_err = 1'b0;
    check("t4_mis_clr", 32'(err_vld_mis), 32'(0));
    check("t4_ovf_clr", 32'(overflow), 32'(0));
    check("t4_drop_clr", 32'(drop_cnt), 32'(0));

    // 5: capture on the last beat of a full FIFO is not a drop
    m_tready = 1'b0;
    drive_triple(32'h61, 32'h62, 32'h63);
    drive_triple(32'h71, 32'h72, 32'h73);
    drive_triple(32'h81, 32'h82, 32'h83);
    drive_triple(32'h91, 32'h92, 32'h93);
    check("t5_full_allow", 32'(start_allow), 32'(0));
    m_tready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (m_tlast) begin
        found = 1'b1;
        break;
      end
      @(negedge ap_clk);
    end
    check("t5_last_seen", 32'(found), 32'(1));
    drive_triple(32'ha1, 32'ha2, 32'ha3);
    check("t5_ovf", 32'(overflow), 32'(0));
    check("t5_drop", 32'(drop_cnt), 32'(0));
    check("t5_allow", 32'(start_allow), 32'(0));
    recv_triple("t5b", 32'h71, 32'h72, 32'h73);
    recv_triple("t5c", 32'h81, 32'h82, 32'h83);
    recv_triple("t5d", 32'h91, 32'h92, 32'h93);
    recv_triple("t5e", 32'ha1, 32'ha2, 32'ha3);
    check("t5_done", 32'(m_tvalid), 32'(0));

    // 6: reset during W1 flushes the partial triple and the queued one
    m_tready = 1'b0;
    drive_triple(32'hb1, 32'hb2, 32'hb3);
    drive_triple(32'hc1, 32'hc2, 32'hc3);
    m_tready = 1'b1;
    @(negedge ap_clk);
    m_tready = 1'b0;
    check("t6_in_w1", m_tdata, 32'hb2);
    ap_rst_n = 1'b0;
    #1;
    check_idle_outputs("t6_rst");
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge ap_clk);
      check("t6_no_stale", 32'(m_tvalid), 32'(0));
    end
    drive_triple(32'hd1, 32'hd2, 32'hd3);
    @(negedge ap_clk);
    recv_triple("t6d", 32'hd1, 32'hd2, 32'hd3);
    check("t6_done", 32'(m_tvalid), 32'(0));

    // 7: drop counter saturates; clear beats a simultaneous drop
    m_tready = 1'b0;
    out13 = 32'h1; out30 = 32'h2; out31 = 32'h3;
    out13_ap_vld = 1'b1; out30_ap_vld = 1'b1; out31_ap_vld = 1'b1;
    repeat (4 + 260) @(negedge ap_clk);
    check("t7_sat", 32'(drop_cnt), 32'd255);
    check("t7_ovf", 32'(overflow), 32'(1));
    check("t7_allow", 32'(start_allow), 32'(0));
    clear_err = 1'b1;
    @(negedge ap_clk);
    clear_err = 1'b0;
    out13_ap_vld = 1'b0; out30_ap_vld = 1'b0; out31_ap_vld = 1'b0;
    check("t7_clr_drop", 32'(drop_cnt), 32'(0));
    check("t7_clr_ovf", 32'(overflow), 32'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
